// File: rtl/alu_response_checker.sv
// Checks a stream of ALU results against an internal table of expected values.
// It counts mismatches over a run of NUM_VEC vectors and records the first one.
module alu_response_checker #(
  parameter int unsigned NUM_VEC = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [4:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [5:0]        err_cnt,
  output logic [4:0]        first_err_idx,
  output logic [DATA_W-1:0] first_err_val
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned TBL_D = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  tbl_q [TBL_D];
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic [DATA_W-1:0]  first_val_q, first_val_d;
  logic               res_ready_q, res_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic accept_c, mismatch_c, start_run_c, last_c;

  // res_ready_q is high exactly in RUN, so acceptance implies RUN
  assign accept_c    = res_valid && res_ready_q;
  assign mismatch_c  = accept_c && (res_data != tbl_q[vec_idx_q]);
  assign start_run_c = start && (state_q != S_RUN);
  assign last_c      = accept_c && (vec_idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Run counters and first-mismatch capture
  always_comb begin
    vec_idx_d   = vec_idx_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_val_d = first_val_q;
    if (start_run_c) begin
      vec_idx_d   = '0;
      err_cnt_d   = '0;
      first_idx_d = '0;
      first_val_d = '0;
    end else if (accept_c) begin
      vec_idx_d = vec_idx_q + IDX_W'(1);
      if (mismatch_c) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (err_cnt_q == '0) begin
          first_idx_d = vec_idx_q;
          first_val_d = res_data;
        end
      end
    end
  end

  // Status flags follow the next state so they line up with the counters
  always_comb begin
    res_ready_d = (state_d == S_RUN);
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    pass_d      = (state_d == S_DONE) && (err_cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_idx_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_val_q <= '0;
      res_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      vec_idx_q   <= vec_idx_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_val_q <= first_val_d;
      res_ready_q <= res_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Expected table: writable only while idle, survives runs, zeroed by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(TBL_D); i++) tbl_q[i] <= '0;
    end else if (exp_we && (state_q == S_IDLE)) begin
      tbl_q[exp_addr] <= exp_data;
    end
  end

  assign res_ready     = res_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_val = first_val_q;

endmodule
